assoc_cache_ctrl: RTL and testbench

Parametrised N-way set-associative write-back, write-allocate cache controller with true-LRU replacement and a handshaked backing-memory port. It generalises our fixed 2-way, 3-bit-tag, 3-bit-data cache to configurable ways, sets, tag width and data width. It sits between a requesting core/testbench and a memory model. One data word per line.

---
 rtl/assoc_cache_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_assoc_cache_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/assoc_cache_ctrl.sv
// assoc_cache_ctrl: N-way set-associative write-back / write-allocate cache
// controller with true-LRU replacement, one data word per line, and a
// handshaked backing-memory port.
// Optional feature macro: CACHE_STATS_EN adds saturating hit/miss counters.
module assoc_cache_ctrl #(
    parameter int  WAYS    = 2,
    parameter int  SETS    = 4,
    parameter int  TAG_W   = 3,
    parameter int  DATA_W  = 3,
    localparam int INDEX_W = $clog2(SETS),
    localparam int ADDR_W  = TAG_W + INDEX_W,
    localparam int WAY_W   = $clog2(WAYS)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              hit_miss,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              wback,
    output logic              mem_req_valid,
    output logic              mem_req_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
`endif
);

    typedef enum logic [2:0] {IDLE, LOOKUP, WBACK, REFILL, RESP} state_t;

    state_t              state_q;
    logic                reqWrite_q;
    logic [ADDR_W-1:0]   reqAddr_q;
    logic [DATA_W-1:0]   reqWdata_q;
    logic [WAY_W-1:0]    victim_q;

    logic                valid_q [SETS][WAYS];
    logic                dirty_q [SETS][WAYS];
    logic [WAY_W-1:0]    age_q   [SETS][WAYS];
    logic [TAG_W-1:0]    tag_q   [SETS][WAYS];
    logic [DATA_W-1:0]   data_q  [SETS][WAYS];

    logic                respValid_q;
    logic                hitMiss_q;
    logic [DATA_W-1:0]   respRdata_q;
    logic                wback_q;
    logic                memReqValid_q;
    logic                memReqWrite_q;
    logic [ADDR_W-1:0]   memAddr_q;
    logic [DATA_W-1:0]   memWdata_q;

    logic [INDEX_W-1:0]  idx;
    logic [TAG_W-1:0]    reqTag;
    logic                hit;
    logic [WAY_W-1:0]    hitWay;
    logic [WAY_W-1:0]    victimWay;
    logic [WAY_W-1:0]    accWay;
    logic [WAY_W-1:0]    accAge;

    assign idx           = reqAddr_q[INDEX_W-1:0];
    assign reqTag        = reqAddr_q[ADDR_W-1:INDEX_W];
    assign req_ready     = (state_q == IDLE);
    assign resp_valid    = respValid_q;
    assign hit_miss      = hitMiss_q;
    assign resp_rdata    = respRdata_q;
    assign wback         = wback_q;
    assign mem_req_valid = memReqValid_q;
    assign mem_req_write = memReqWrite_q;
    assign mem_addr      = memAddr_q;
    assign mem_wdata     = memWdata_q;

    // Tag match across the set, victim choice (lowest invalid way, else the
    // oldest way), and the way/age whose access drives the LRU update.
    always_comb begin
        hit       = 1'b0;
        hitWay    = '0;
        victimWay = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && (tag_q[idx][w] == reqTag)) begin
                hit    = 1'b1;
                hitWay = WAY_W'(w);
            end
            if (age_q[idx][w] == WAY_W'(WAYS - 1)) begin
                victimWay = WAY_W'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[idx][w]) begin
                victimWay = WAY_W'(w);
            end
        end
        accWay = (state_q == LOOKUP) ? hitWay : victim_q;
        accAge = age_q[idx][accWay];
    end

    // Main controller FSM: owns state, line metadata (valid/dirty/age) and all
    // registered outputs, so reset clears them asynchronously.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            reqWrite_q    <= 1'b0;
            reqAddr_q     <= '0;
            reqWdata_q    <= '0;
            victim_q      <= '0;
            respValid_q   <= 1'b0;
            hitMiss_q     <= 1'b0;
            respRdata_q   <= '0;
            wback_q       <= 1'b0;
            memReqValid_q <= 1'b0;
            memReqWrite_q <= 1'b0;
            memAddr_q     <= '0;
            memWdata_q    <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    age_q[s][w]   <= WAY_W'(w);
                end
            end
        end else begin
            respValid_q <= 1'b0;
            wback_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        reqWrite_q <= req_write;
                        reqAddr_q  <= req_addr;
                        reqWdata_q <= req_wdata;
                        state_q    <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        for (int w = 0; w < WAYS; w++) begin
                            if (age_q[idx][w] < accAge) begin
                                age_q[idx][w] <= age_q[idx][w] + 1'b1;
                            end
                        end
                        age_q[idx][hitWay] <= '0;
                        if (reqWrite_q) begin
                            dirty_q[idx][hitWay] <= 1'b1;
                        end
                        respRdata_q <= reqWrite_q ? reqWdata_q : data_q[idx][hitWay];
                        hitMiss_q   <= 1'b1;
                        respValid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        victim_q      <= victimWay;
                        memReqValid_q <= 1'b1;
                        if (valid_q[idx][victimWay] && dirty_q[idx][victimWay]) begin
                            memReqWrite_q <= 1'b1;
                            memAddr_q     <= {tag_q[idx][victimWay], idx};
                            memWdata_q    <= data_q[idx][victimWay];
                            state_q       <= WBACK;
                        end else begin
                            memReqWrite_q <= 1'b0;
                            memAddr_q     <= reqAddr_q;
                            state_q       <= REFILL;
                        end
                    end
                end
                WBACK: begin
                    if (mem_ack) begin
                        wback_q       <= 1'b1;
                        memReqWrite_q <= 1'b0;
                        memAddr_q     <= reqAddr_q;
                        state_q       <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_ack) begin
                        for (int w = 0; w < WAYS; w++) begin
                            if (age_q[idx][w] < accAge) begin
                                age_q[idx][w] <= age_q[idx][w] + 1'b1;
                            end
                        end
                        age_q[idx][victim_q]   <= '0;
                        valid_q[idx][victim_q] <= 1'b1;
                        dirty_q[idx][victim_q] <= reqWrite_q;
                        memReqValid_q          <= 1'b0;
                        respRdata_q            <= reqWrite_q ? reqWdata_q : mem_rdata;
                        hitMiss_q              <= 1'b0;
                        respValid_q            <= 1'b1;
                        state_q                <= RESP;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Tag and data storage carry no reset; validity is tracked separately.
    always_ff @(posedge clock) begin
        if ((state_q == LOOKUP) && hit && reqWrite_q) begin
            data_q[idx][hitWay] <= reqWdata_q;
        end
        if ((state_q == REFILL) && mem_ack) begin
            tag_q[idx][victim_q]  <= reqTag;
            data_q[idx][victim_q] <= reqWrite_q ? reqWdata_q : mem_rdata;
        end
    end

`ifdef CACHE_STATS_EN
    logic [15:0] hitCount_q;
    logic [15:0] missCount_q;

    assign hit_count  = hitCount_q;
    assign miss_count = missCount_q;

    // Saturating hit/miss counters, bumped once per response.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hitCount_q  <= '0;
            missCount_q <= '0;
        end else if (state_q == RESP) begin
            if (hitMiss_q) begin
                if (hitCount_q != 16'hFFFF) begin
                    hitCount_q <= hitCount_q + 16'd1;
                end
            end else begin
                if (missCount_q != 16'hFFFF) begin
                    missCount_q <= missCount_q + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// tb_assoc_cache_ctrl: directed, table-driven bench for assoc_cache_ctrl at
// default parameters, with a small behavioural memory and hand-written
// sequences for the stall and mid-transaction reset cases.
// Optional feature macro: CACHE_STATS_EN enables the counter checks.
module tb_assoc_cache_ctrl;

    logic       clock;
    logic       reset_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [4:0] req_addr;
    logic [2:0] req_wdata;
    logic       resp_valid;
    logic       hit_miss;
    logic [2:0] resp_rdata;
    logic       wback;
    logic       mem_req_valid;
    logic       mem_req_write;
    logic [4:0] mem_addr;
    logic [2:0] mem_wdata;
    logic       mem_ack;
    logic [2:0] mem_rdata;
`ifdef CACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    assoc_cache_ctrl dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .hit_miss     (hit_miss),
        .resp_rdata   (resp_rdata),
        .wback        (wback),
        .mem_req_valid(mem_req_valid),
        .mem_req_write(mem_req_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata)
`ifdef CACHE_STATS_EN
        ,
        .hit_count    (hit_count),
        .miss_count   (miss_count)
`endif
    );

    typedef struct {
        logic       write;
        logic [4:0] addr;
        logic [2:0] wdata;
        int         delay;
        logic       expHit;
        logic [2:0] expData;
        int         expWb;
        int         expLat;
        logic [4:0] expWbAddr;
        logic [2:0] expWbData;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    int         checks = 0;
    int         errors = 0;
    int         ackDelay = 0;
    int         refillCount = 0;
    int         wbCount = 0;
    int         wbackPulses = 0;
    logic [4:0] lastRefillAddr = '0;
    logic [4:0] lastWbAddr = '0;
    logic [2:0] lastWbData = '0;
    logic [2:0] memArr [32];

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural memory: acks after ackDelay idle cycles, reinitialised in reset.
    initial begin
        int  cnt;
        logic prevAck;
        cnt       = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clock);
            prevAck = mem_ack;
            mem_ack = 1'b0;
            if (!reset_n) begin
                cnt = 0;
                for (int i = 0; i < 32; i++) memArr[i] = 3'((i * 3 + 1) % 8);
                memArr[21] = 3'd3;
            end else begin
                if (prevAck) cnt = 0;
                if (mem_req_valid) begin
                    if (cnt >= ackDelay) begin
                        mem_ack   = 1'b1;
                        mem_rdata = memArr[mem_addr];
                        if (mem_req_write) begin
                            memArr[mem_addr] = mem_wdata;
                            lastWbAddr = mem_addr;
                            lastWbData = mem_wdata;
                            wbCount++;
                        end else begin
                            lastRefillAddr = mem_addr;
                            refillCount++;
                        end
                    end else begin
                        cnt++;
                    end
                end else begin
                    cnt = 0;
                end
            end
        end
    end

    // Counts write-back completion pulses seen on the DUT output.
    initial begin
        forever begin
            @(negedge clock);
            if (wback) wbackPulses++;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic [4:0] addr, input logic [2:0] wd,
                                 input int dly, output logic gotHit, output logic [2:0] gotData,
                                 output int lat);
        int guard;
        ackDelay = dly;
        gotHit   = 1'b0;
        gotData  = '0;
        guard    = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL ready_timeout actual=0 required=1");
        end
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        @(negedge clock);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 60) begin
            @(negedge clock);
            lat++;
        end
        if (!resp_valid) begin
            checks++;
            errors++;
            $display("[TB] FAIL resp_timeout actual=0 required=1");
        end else begin
            gotHit  = hit_miss;
            gotData = resp_rdata;
        end
    endtask

    initial begin
        logic       gotHit;
        logic [2:0] gotData;
        int         lat;
        int         w0, r0, m0;
        int         guard;
        logic [4:0] heldAddr;
        logic       heldWrite;
        logic       sawResp;

        // {write, addr, wdata, delay, expHit, expData, expWb, expLat, wbAddr, wbData}
        vecs[0]  = '{1'b0, 5'b101_01, 3'd0, 0, 1'b0, 3'd3, 0, 3, 5'd0,      3'd0};
        vecs[1]  = '{1'b0, 5'b101_01, 3'd0, 0, 1'b1, 3'd3, 0, 2, 5'd0,      3'd0};
        vecs[2]  = '{1'b1, 5'b010_00, 3'd6, 1, 1'b0, 3'd6, 0, 4, 5'd0,      3'd0};
        vecs[3]  = '{1'b1, 5'b011_00, 3'd1, 0, 1'b0, 3'd1, 0, 3, 5'd0,      3'd0};
        vecs[4]  = '{1'b0, 5'b100_00, 3'd0, 0, 1'b0, 3'd1, 1, 4, 5'b010_00, 3'd6};
        vecs[5]  = '{1'b0, 5'b010_00, 3'd0, 0, 1'b0, 3'd6, 1, 4, 5'b011_00, 3'd1};
        vecs[6]  = '{1'b0, 5'b001_10, 3'd0, 0, 1'b0, 3'd3, 0, 3, 5'd0,      3'd0};
        vecs[7]  = '{1'b0, 5'b010_10, 3'd0, 2, 1'b0, 3'd7, 0, 5, 5'd0,      3'd0};
        vecs[8]  = '{1'b0, 5'b001_10, 3'd0, 0, 1'b1, 3'd3, 0, 2, 5'd0,      3'd0};
        vecs[9]  = '{1'b0, 5'b011_10, 3'd0, 0, 1'b0, 3'd3, 0, 3, 5'd0,      3'd0};
        vecs[10] = '{1'b0, 5'b001_10, 3'd0, 0, 1'b1, 3'd3, 0, 2, 5'd0,      3'd0};
        vecs[11] = '{1'b1, 5'b001_10, 3'd5, 0, 1'b1, 3'd5, 0, 2, 5'd0,      3'd0};
        vecs[12] = '{1'b0, 5'b001_10, 3'd0, 0, 1'b1, 3'd5, 0, 2, 5'd0,      3'd0};
        vecs[13] = '{1'b0, 5'b111_11, 3'd0, 0, 1'b0, 3'd6, 0, 3, 5'd0,      3'd0};
        vecs[14] = '{1'b0, 5'b111_11, 3'd0, 0, 1'b1, 3'd6, 0, 2, 5'd0,      3'd0};

        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        reset_n   = 1'b1;
        #2 reset_n = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checkOutput("rst_req_ready", req_ready, 1);
        checkOutput("rst_resp_valid", resp_valid, 0);
        checkOutput("rst_hit_miss", hit_miss, 0);
        checkOutput("rst_resp_rdata", resp_rdata, 0);
        checkOutput("rst_wback", wback, 0);
        checkOutput("rst_mem_req_valid", mem_req_valid, 0);
        checkOutput("rst_mem_req_write", mem_req_write, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_mem_wdata", mem_wdata, 0);
        reset_n = 1'b1;
        @(negedge clock);

        for (int i = 0; i < NV; i++) begin
            w0 = wbackPulses;
            r0 = refillCount;
            m0 = wbCount;
            applyStimulus(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].delay,
                          gotHit, gotData, lat);
            checkOutput($sformatf("v%0d_hit", i), gotHit, vecs[i].expHit);
            checkOutput($sformatf("v%0d_rdata", i), gotData, vecs[i].expData);
            checkOutput($sformatf("v%0d_latency", i), lat, vecs[i].expLat);
            checkOutput($sformatf("v%0d_wback_pulses", i), wbackPulses - w0, vecs[i].expWb);
            checkOutput($sformatf("v%0d_mem_writes", i), wbCount - m0, vecs[i].expWb);
            checkOutput($sformatf("v%0d_refills", i), refillCount - r0, vecs[i].expHit ? 0 : 1);
            if (!vecs[i].expHit) begin
                checkOutput($sformatf("v%0d_refill_addr", i), lastRefillAddr, vecs[i].addr);
            end
            if (vecs[i].expWb != 0) begin
                checkOutput($sformatf("v%0d_wb_addr", i), lastWbAddr, vecs[i].expWbAddr);
                checkOutput($sformatf("v%0d_wb_data", i), lastWbData, vecs[i].expWbData);
            end
`ifdef CACHE_STATS_EN
            if (i == 1) begin
                @(negedge clock);
                checkOutput("stats_hit_count", hit_count, 1);
                checkOutput("stats_miss_count", miss_count, 1);
            end
`endif
        end

        // Stalled refill: memory holds off, request path must stay frozen.
        ackDelay = 5;
        @(negedge clock);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 5'b000_01;
        @(negedge clock);
        req_valid = 1'b0;
        guard = 0;
        while (!mem_req_valid && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        checkOutput("stall_mem_req_valid", mem_req_valid, 1);
        heldAddr  = mem_addr;
        heldWrite = mem_req_write;
        checkOutput("stall_mem_addr_start", heldAddr, 5'b000_01);
        checkOutput("stall_mem_write_start", heldWrite, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            if (k == 1) begin
                req_valid = 1'b1;
                req_addr  = 5'b111_01;
            end
            if (k == 2) req_valid = 1'b0;
            checkOutput($sformatf("stall%0d_req_ready", k), req_ready, 0);
            checkOutput($sformatf("stall%0d_mem_addr", k), mem_addr, heldAddr);
            checkOutput($sformatf("stall%0d_mem_write", k), mem_req_write, heldWrite);
        end
        guard = 0;
        while (!resp_valid && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        checkOutput("stall_resp_valid", resp_valid, 1);
        checkOutput("stall_hit", hit_miss, 0);
        checkOutput("stall_rdata", resp_rdata, 4);
        r0 = refillCount;
        sawResp = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            if (resp_valid) sawResp = 1'b1;
        end
        checkOutput("stall_no_extra_resp", sawResp, 0);
        checkOutput("stall_no_extra_refill", refillCount - r0, 0);
        checkOutput("stall_ready_after", req_ready, 1);

        // Reset while a dirty victim write-back is outstanding.
        applyStimulus(1'b1, 5'b000_11, 3'd2, 0, gotHit, gotData, lat);
        checkOutput("rw_setup_miss", gotHit, 0);
        applyStimulus(1'b1, 5'b111_11, 3'd4, 0, gotHit, gotData, lat);
        checkOutput("rw_setup_hit", gotHit, 1);
        ackDelay = 10;
        @(negedge clock);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 5'b010_11;
        @(negedge clock);
        req_valid = 1'b0;
        guard = 0;
        while (!mem_req_valid && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        checkOutput("rw_wback_active", mem_req_valid, 1);
        checkOutput("rw_wback_write", mem_req_write, 1);
        checkOutput("rw_wback_addr", mem_addr, 5'b000_11);
        checkOutput("rw_wback_data", mem_wdata, 2);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("rw_async_mem_req_valid", mem_req_valid, 0);
        checkOutput("rw_async_req_ready", req_ready, 1);
        sawResp = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            if (resp_valid) sawResp = 1'b1;
        end
        checkOutput("rw_no_resp", sawResp, 0);
        reset_n = 1'b1;
        @(negedge clock);
        applyStimulus(1'b0, 5'b111_11, 3'd0, 0, gotHit, gotData, lat);
        checkOutput("rw_after_hit", gotHit, 0);
        checkOutput("rw_after_rdata", gotData, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
